// File: rtl/button_debouncer.sv
// Multi-channel push-button synchroniser and debouncer: raw switch contacts in,
// clean active-high levels out, each changing only after a stable interval.

module button_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic sync,
  output logic stable,
  output logic busy
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'b00,
    PEND_HIGH   = 2'b01,
    STABLE_HIGH = 2'b11,
    PEND_LOW    = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_d, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      stable  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stable  <= stable_d;
      busy    <= busy_d;
    end
  end

  // The first differing sample already counts as observation 1, so a change
  // commits once cnt has reached DEBOUNCE_CYCLES-1 and s1 still differs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    stable_d = stable;
    case (state_q)
      STABLE_LOW: begin
        stable_d = 1'b0;
        if (sync) begin
          state_d = PEND_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_HIGH: begin
        if (!sync) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_HIGH;
          stable_d = 1'b1;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        stable_d = 1'b1;
        if (!sync) begin
          state_d = PEND_LOW;
          cnt_d   = CNT_ONE;
        end
      end
      PEND_LOW: begin
        if (sync) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = STABLE_LOW;
          stable_d = 1'b0;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d  = STABLE_LOW;
        stable_d = 1'b0;
        cnt_d    = '0;
      end
    endcase
    busy_d = (state_d == PEND_HIGH) || (state_d == PEND_LOW);
  end
endmodule

module button_debouncer #(
  parameter int N_BTN           = 5,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_stable,
  output logic [N_BTN-1:0] btn_busy
);
  logic [N_BTN-1:0] norm, s0, s1;

  // Normalise polarity before synchronising so reset clears to "released".
  assign norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
      s1 <= '0;
    end else begin
      s0 <= norm;
      s1 <= s0;
    end
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    button_debouncer_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .sync  (s1[i]),
      .stable(btn_stable[i]),
      .busy  (btn_busy[i])
    );
  end
endmodule
